// File: rtl/med_stream_filter.sv
// Streaming 3-tap median filter over a valid/ready line stream.
// Edge samples are replicated so each line yields exactly N outputs.
module med_stream_filter #(
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] w_prev_q, w_prev_d;
  logic [DW-1:0] w_cur_q, w_cur_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          out_valid_q, out_valid_d;

  logic          slot_free;
  logic          accept;
  logic          load;
  logic [DW-1:0] ld_data;
  logic          ld_last;

  function automatic logic [DW-1:0] med3(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic [DW-1:0] c
  );
    logic [DW-1:0] lo, hi, m;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    m  = (hi < c) ? hi : c;
    return (lo > m) ? lo : m;
  endfunction

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = slot_free && (state_q != FLUSH);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    w_prev_d = w_prev_q;
    w_cur_d  = w_cur_q;
    load     = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            load    = 1'b1;
            ld_data = in_data;
            ld_last = 1'b1;
          end else begin
            w_prev_d = in_data;
            w_cur_d  = in_data;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          load     = 1'b1;
          ld_data  = med3(w_prev_q, w_cur_q, in_data);
          w_prev_d = w_cur_q;
          w_cur_d  = in_data;
          if (in_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = med3(w_prev_q, w_cur_q, w_cur_q);
          ld_last = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load and drain may coincide, keeping one sample per cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = ld_data;
      out_last_d  = ld_last;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_prev_q    <= '0;
      w_cur_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_prev_q    <= w_prev_d;
      w_cur_q     <= w_cur_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_med_stream_filter.sv
// Scoreboard bench for med_stream_filter: line-level median model,
// randomized valid/ready, decoupled output monitor.
module tb_med_stream_filter;

  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  int checks = 0;
  int errors = 0;
  int ready_pct = 100;
  int exp_q[$];

  logic          stall_pend = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  med_stream_filter #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: sort the edge-replicated 3-window, take the middle.
  task automatic push_line(input int xs[$]);
    int n, w[3], t;
    n = xs.size();
    for (int k = 0; k < n; k++) begin
      w[0] = xs[(k == 0) ? 0 : k - 1];
      w[1] = xs[k];
      w[2] = xs[(k == n - 1) ? n - 1 : k + 1];
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2 - i; j++)
          if (w[j] > w[j+1]) begin
            t = w[j]; w[j] = w[j+1]; w[j+1] = t;
          end
      exp_q.push_back(w[1] + ((k == n - 1) ? 256 : 0));
    end
  endtask

  always @(posedge clk) begin
    #1 out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(hold_d));
        chk("stall_last", int'(out_last), int'(hold_l));
      end
      stall_pend = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), e % 256);
          chk("out_last", int'(out_last), e / 256);
        end
      end
    end
  end

  // Drives one sample; returns cycles spent waiting for in_ready.
  task automatic send(input int d, input bit last, output int waits);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = DW'(d);
    in_last  = last;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 1000) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_line(input int xs[$], input int gap_pct);
    int w;
    push_line(xs);
    foreach (xs[i]) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      send(xs[i], i == xs.size() - 1, w);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int w, n;
    int xs[$];
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    #1 rst = 1'b0;

    // 5,1,7,3 -> 5,5,3,3 with one bubble
    ready_pct = 100;
    send_line('{5, 1, 7, 3}, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("flush_bubble", int'(in_ready), 0);
    @(negedge clk);
    chk("after_bubble", int'(in_ready), 1);
    drain();

    // single-sample line then 2,7: no bubble after the 6
    push_line('{6});
    send(6, 1'b1, w);
    push_line('{2, 7});
    send(2, 1'b0, w);
    chk("n1_no_bubble", w, 0);
    send(7, 1'b1, w);
    idle(1);
    drain();

    // 0,7,0,7,0 under random backpressure
    ready_pct = 50;
    send_line('{0, 7, 0, 7, 0}, 0);
    idle(1);
    drain();

    // equal values, then back-to-back lines
    ready_pct = 100;
    send_line('{4, 4, 1, 4}, 0);
    send_line('{1, 6, 6}, 0);
    send_line('{7, 0}, 0);
    idle(1);
    drain();

    // reset mid-line discards partial window and pending output
    send(3, 1'b0, w);
    send(6, 1'b0, w);
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    send_line('{1, 2, 3}, 0);
    idle(1);
    drain();

    // random lines
    for (int l = 0; l < 60; l++) begin
      ready_pct = $urandom_range(30, 100);
      n = $urandom_range(1, 20);
      xs = {};
      for (int i = 0; i < n; i++) xs.push_back($urandom_range(0, 7));
      send_line(xs, $urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(1);
    ready_pct = 100;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
